// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: issues one data-bus access per instruction,
// stalls the pipeline until the response arrives, then aligns and extends load data.
module mem_access_unit #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic [2:0]  mem_op_mem,
    input  logic        is_load_mem,
    input  logic        is_store_mem,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        mem_done_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  op_q, op_d;
    logic        ld_q, ld_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [1:0]  off;
    logic        mem_op;
    logic        aligned;
    logic        access;
    logic        is_st;
    logic        timeout_hit;
    logic        issuing;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign off         = alu_result_mem[1:0];
    assign mem_op      = is_load_mem | is_store_mem;
    // Both flags high is resolved as a load.
    assign is_st       = is_store_mem & ~is_load_mem;
    assign timeout_hit = (cnt_q == 16'(RSP_TIMEOUT));
    assign access      = mem_op & aligned;

    always_comb begin
        aligned = 1'b1;
        case (mem_op_mem[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~off[0];
            default: aligned = (off == 2'b00);
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            rdata_q <= '0;
            off_q   <= '0;
            op_q    <= '0;
            ld_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            off_q   <= off_d;
            op_q    <= op_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        off_d   = off_q;
        op_d    = op_q;
        ld_d    = ld_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    off_d   = off;
                    op_d    = mem_op_mem;
                    ld_d    = is_load_mem;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = dmem_gnt_i ? WAIT_RSP : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (dmem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response in the timeout cycle still wins over the error.
                if (dmem_rvalid_i) begin
                    rdata_d = dmem_rdata_i;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_byte = rdata_q[7:0];
        case (off_q)
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            2'd3: ld_byte = rdata_q[31:24];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    // Output logic
    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0000;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        stall_o      = 1'b0;
        load_data_o  = '0;
        mem_done_o   = 1'b0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;
        state_dbg_o  = state_q;

        issuing = rstn && (((state_q == IDLE) && access) || (state_q == WAIT_GNT));

        if (issuing) begin
            dmem_req_o  = 1'b1;
            dmem_addr_o = {alu_result_mem[31:2], 2'b00};
            if (is_st) begin
                dmem_we_o = 1'b1;
                case (mem_op_mem[1:0])
                    2'b00: begin
                        dmem_be_o    = 4'b0001 << off;
                        dmem_wdata_o = {4{rs2_data_mem[7:0]}};
                    end
                    2'b01: begin
                        dmem_be_o    = 4'b0011 << off;
                        dmem_wdata_o = {2{rs2_data_mem[15:0]}};
                    end
                    default: begin
                        dmem_be_o    = 4'b1111;
                        dmem_wdata_o = rs2_data_mem;
                    end
                endcase
            end else begin
                dmem_be_o = 4'b1111;
            end
        end

        stall_o = issuing || (rstn && (state_q == WAIT_RSP));

        if (rstn && (state_q == IDLE) && mem_op && !aligned) begin
            misaligned_o = 1'b1;
        end

        if (rstn && (state_q == DONE)) begin
            mem_done_o = 1'b1;
            bus_err_o  = err_q;
            if (ld_q && !err_q) begin
                case (op_q)
                    3'b000:  load_data_o = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  load_data_o = {{16{ld_half[15]}}, ld_half};
                    3'b100:  load_data_o = {24'd0, ld_byte};
                    3'b101:  load_data_o = {16'd0, ld_half};
                    default: load_data_o = rdata_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: cycle-exact bus handshakes with
// hand-computed byte enables, store lanes and extended load results.
module tb_mem_access_unit;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rstn;
    logic [31:0] alu_result_mem;
    logic [31:0] rs2_data_mem;
    logic [2:0]  mem_op_mem;
    logic        is_load_mem;
    logic        is_store_mem;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        mem_done_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic [1:0]  state_dbg_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.RSP_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .alu_result_mem (alu_result_mem),
        .rs2_data_mem   (rs2_data_mem),
        .mem_op_mem     (mem_op_mem),
        .is_load_mem    (is_load_mem),
        .is_store_mem   (is_store_mem),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .stall_o        (stall_o),
        .load_data_o    (load_data_o),
        .mem_done_o     (mem_done_o),
        .misaligned_o   (misaligned_o),
        .bus_err_o      (bus_err_o),
        .state_dbg_o    (state_dbg_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        is_load_mem    = 1'b0;
        is_store_mem   = 1'b0;
        mem_op_mem     = 3'b000;
        alu_result_mem = '0;
        rs2_data_mem   = '0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
        dmem_rdata_i   = '0;
    endtask

    task automatic check_done_data(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 32'd1, 32'd0);
        end else begin
            check(tag, load_data_o, exp_q.pop_front());
        end
    endtask

    // Full access from IDLE: request, gnt after gnt_dly cycles, rvalid after rsp_dly WAIT_RSP cycles.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gnt_dly, input int rsp_dly, input logic [31:0] rdata,
                              input logic [3:0] exp_be, input logic exp_we,
                              input logic [31:0] exp_wdata);
        is_load_mem    = ld;
        is_store_mem   = st;
        mem_op_mem     = op;
        alu_result_mem = addr;
        rs2_data_mem   = wd;
        dmem_gnt_i     = (gnt_dly == 0);
        #1;
        check("req_idle", 32'(dmem_req_o), 32'd1);
        check("stall_idle", 32'(stall_o), 32'd1);
        check("be", 32'(dmem_be_o), 32'(exp_be));
        check("we", 32'(dmem_we_o), 32'(exp_we));
        check("addr", dmem_addr_o, {addr[31:2], 2'b00});
        if (exp_we) check("wdata", dmem_wdata_o, exp_wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            cyc();
            dmem_gnt_i = (i == gnt_dly - 1);
            #1;
            check("state_wgnt", 32'(state_dbg_o), 32'd1);
            check("req_held", 32'(dmem_req_o), 32'd1);
            check("be_held", 32'(dmem_be_o), 32'(exp_be));
            if (exp_we) check("wdata_held", dmem_wdata_o, exp_wdata);
        end
        cyc();
        dmem_gnt_i = 1'b0;
        #1;
        check("state_wrsp", 32'(state_dbg_o), 32'd2);
        check("req_wrsp", 32'(dmem_req_o), 32'd0);
        for (int j = 0; j < rsp_dly; j++) begin
            cyc();
            #1;
            check("stall_wrsp", 32'(stall_o), 32'd1);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        #1;
        check("stall_rsp", 32'(stall_o), 32'd1);
        cyc();
        dmem_rvalid_i = 1'b0;
        #1;
        check("done", 32'(mem_done_o), 32'd1);
        check("stall_done", 32'(stall_o), 32'd0);
        check("bus_err_done", 32'(bus_err_o), 32'd0);
        check_done_data("load_data");
        cyc();
        clear_inputs();
        #1;
        check("done_clear", 32'(mem_done_o), 32'd0);
        check("state_idle", 32'(state_dbg_o), 32'd0);
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        cyc();
        cyc();
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_done", 32'(mem_done_o), 32'd0);
        check("rst_ld", load_data_o, 32'd0);
        check("rst_state", 32'(state_dbg_o), 32'd0);
        rstn = 1'b1;

        // LW 0x100, gnt immediately, rvalid next cycle
        exp_q.push_back(32'hDEADBEEF);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, 0, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0);
        // LB / LBU at 0x103
        exp_q.push_back(32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 0, 32'h8012_3456, 4'hF, 1'b0, 32'd0);
        exp_q.push_back(32'h0000_0080);
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 0, 1, 32'h8012_3456, 4'hF, 1'b0, 32'd0);
        // LH upper half, LHU lower half
        exp_q.push_back(32'hFFFF_8001);
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 1, 0, 32'h8001_7FFF, 4'hF, 1'b0, 32'd0);
        exp_q.push_back(32'h0000_8765);
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'd0, 0, 2, 32'h1234_8765, 4'hF, 1'b0, 32'd0);
        // SH 0x102, gnt after 3 cycles
        exp_q.push_back(32'd0);
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 3, 0, 32'hFFFF_FFFF, 4'b1100, 1'b1, 32'hABCD_ABCD);
        // SB 0x101, SW 0x104
        exp_q.push_back(32'd0);
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h5566_77EF, 1, 1, 32'd0, 4'b0010, 1'b1, 32'hEFEF_EFEF);
        exp_q.push_back(32'd0);
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 0, 0, 32'd0, 4'b1111, 1'b1, 32'hCAFE_F00D);
        // Load and store both high behaves as a load
        exp_q.push_back(32'h0BAD_CAFE);
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_0108, 32'h1111_1111, 0, 0, 32'h0BAD_CAFE, 4'hF, 1'b0, 32'd0);
        // rvalid in the exact timeout cycle is accepted
        exp_q.push_back(32'h1357_9BDF);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0110, 32'd0, 0, TMO, 32'h1357_9BDF, 4'hF, 1'b0, 32'd0);

        // Misaligned LW and SH
        is_load_mem = 1'b1; mem_op_mem = 3'b010; alu_result_mem = 32'h0000_0101; dmem_gnt_i = 1'b1;
        #1;
        check("mis_lw_flag", 32'(misaligned_o), 32'd1);
        check("mis_lw_req", 32'(dmem_req_o), 32'd0);
        check("mis_lw_stall", 32'(stall_o), 32'd0);
        cyc();
        check("mis_lw_state", 32'(state_dbg_o), 32'd0);
        clear_inputs();
        is_store_mem = 1'b1; mem_op_mem = 3'b001; alu_result_mem = 32'h0000_0103;
        #1;
        check("mis_sh_flag", 32'(misaligned_o), 32'd1);
        check("mis_sh_req", 32'(dmem_req_o), 32'd0);
        cyc();
        check("mis_sh_state", 32'(state_dbg_o), 32'd0);
        clear_inputs();
        #1;
        check("nomem_mis", 32'(misaligned_o), 32'd0);
        check("nomem_stall", 32'(stall_o), 32'd0);

        // Timeout: no rvalid, then a stray rvalid afterwards
        is_load_mem = 1'b1; mem_op_mem = 3'b010; alu_result_mem = 32'h0000_010C; dmem_gnt_i = 1'b1;
        #1;
        cyc();
        dmem_gnt_i = 1'b0;
        #1;
        check("tmo_state", 32'(state_dbg_o), 32'd2);
        for (int k = 1; k <= int'(TMO); k++) begin
            cyc();
            #1;
            check("tmo_stall", 32'(stall_o), 32'd1);
        end
        cyc();
        #1;
        check("tmo_done", 32'(mem_done_o), 32'd1);
        check("tmo_err", 32'(bus_err_o), 32'd1);
        check("tmo_ld", load_data_o, 32'd0);
        clear_inputs();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
        cyc();
        #1;
        check("tmo_after_done", 32'(mem_done_o), 32'd0);
        check("tmo_after_err", 32'(bus_err_o), 32'd0);
        check("tmo_after_state", 32'(state_dbg_o), 32'd0);
        cyc();
        dmem_rvalid_i = 1'b0;
        #1;
        check("stray_state", 32'(state_dbg_o), 32'd0);

        // Reset while waiting for the response
        is_load_mem = 1'b1; mem_op_mem = 3'b010; alu_result_mem = 32'h0000_0120; dmem_gnt_i = 1'b1;
        #1;
        cyc();
        dmem_gnt_i = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_wrsp_stall", 32'(stall_o), 32'd0);
        check("rst_wrsp_req", 32'(dmem_req_o), 32'd0);
        cyc();
        rstn = 1'b1;
        clear_inputs();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h9999_9999;
        #1;
        check("rst_idle_state", 32'(state_dbg_o), 32'd0);
        check("rst_idle_done", 32'(mem_done_o), 32'd0);
        check("rst_idle_ld", load_data_o, 32'd0);
        cyc();
        dmem_rvalid_i = 1'b0;
        #1;
        check("rst_late_done", 32'(mem_done_o), 32'd0);
        check("rst_late_state", 32'(state_dbg_o), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
